gold_ring_inport: RTL

//  Input port of the gold ring router; the stage directly downstream of the NIC network interface.

---
 rtl/gold_ring_inport_if.sv | 14 +
 rtl/gold_ring_inport.sv | 68 ++++++
 2 files changed

// File: rtl/gold_ring_inport_if.sv
// gold_ring_inport_if: NIC send link, drain port and polarity/error signals of the gold ring input port.
interface gold_ring_inport_if #(parameter int DW = 64);
  logic          polarity;
  logic          si;
  logic          ri;
  logic [0:DW-1] di;
  logic          out_valid;
  logic          out_ready;
  logic [0:DW-1] out_data;
  logic          out_eject;
  logic          vc_err;
  modport slave (input polarity, si, di, out_ready, output ri, out_valid, out_data, out_eject, vc_err);
  modport master (output polarity, si, di, out_ready, input ri, out_valid, out_data, out_eject, vc_err);
endinterface

// File: rtl/gold_ring_inport.sv
// gold_ring_inport: two polarity-indexed VC FIFOs; writes VC=polarity, drains VC=~polarity with hop shift.
// Optional GOLD_INPORT_STATS_EN adds pkt_count (saturating accepted pushes) and drop_stall.
module gold_ring_inport #(
  parameter int DEPTH = 2,
  parameter int DW    = 64
) (
  input  logic clk,
  input  logic reset,
  gold_ring_inport_if.slave bus
`ifdef GOLD_INPORT_STATS_EN
  ,
  output logic [0:15] pkt_count,
  output logic        drop_stall
`endif
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [0:DW-1] r_mem [2][DEPTH];
  logic [AW-1:0] r_wp [2];
  logic [AW-1:0] r_rp [2];
  logic [CW-1:0] r_cnt [2];
  logic          r_vc_err;
  logic          w_wvc, w_rvc, w_push, w_pop;
  logic [0:DW-1] w_head;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction
  assign w_wvc         = bus.polarity;
  assign w_rvc         = ~bus.polarity;
  assign bus.ri        = ~reset & (r_cnt[w_wvc] != CW'(DEPTH));
  assign w_push        = bus.si & bus.ri;
  assign bus.out_valid = r_cnt[w_rvc] != '0;
  assign w_pop         = bus.out_valid & bus.out_ready;
  assign w_head        = r_mem[w_rvc][r_rp[w_rvc]];
  // hop field [8:15] is shifted right one place on the way out; MSB [8] zero-filled
  assign bus.out_data  = bus.out_valid ? {w_head[0:7], 1'b0, w_head[8:14], w_head[16:DW-1]} : '0;
  assign bus.out_eject = bus.out_valid & w_head[15];
  assign bus.vc_err    = r_vc_err;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int v = 0; v < 2; v++) begin
        r_wp[v]  <= '0;
        r_rp[v]  <= '0;
        r_cnt[v] <= '0;
      end
      r_vc_err <= 1'b0;
    end else begin
      r_vc_err <= w_push & (bus.di[0] != bus.polarity);
      if (w_push) begin
        r_wp[w_wvc]  <= inc(r_wp[w_wvc]);
        r_cnt[w_wvc] <= r_cnt[w_wvc] + CW'(1);
      end
      if (w_pop) begin
        r_rp[w_rvc]  <= inc(r_rp[w_rvc]);
        r_cnt[w_rvc] <= r_cnt[w_rvc] - CW'(1);
      end
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[w_wvc][r_wp[w_wvc]] <= bus.di;
`ifdef GOLD_INPORT_STATS_EN
  logic [0:15] r_pkt_count;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_pkt_count <= '0;
    else if (w_push && r_pkt_count != 16'hFFFF) r_pkt_count <= r_pkt_count + 16'd1;
  assign pkt_count  = r_pkt_count;
  assign drop_stall = bus.si & ~bus.ri;
`endif
endmodule
